// File: rtl/fifo_nibble_packer.sv
// rtl/fifo_nibble_packer.sv - packs P consecutive FIFO entries into one W-bit output word
//
// Drains the synchronous FIFO, which has a read latency of one cycle, and assembles
// P entries per word, first entry at the LSB. A flush closes a partial word, zero-pads
// it and reports how many entries are valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO registered read data, valid the cycle after fifo_rd
//   fifo_rd    FIFO read strobe
//   flush      level request: stop reading and close the partial word
//   out_valid  packed word available
//   out_ready  downstream accepts when out_valid && out_ready
//   out_data   packed word, entry k in bits [k*M +: M]
//   out_cnt    number of valid entries in out_data
module fifo_nibble_packer #(
  parameter  int M  = 4,
  parameter  int P  = 4,
  localparam int W  = M * P,
  localparam int CW = $clog2(P + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic [M-1:0]  fifo_data,
  output logic          fifo_rd,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_cnt
);

  localparam logic [CW-1:0] CNT_FULL = CW'(P);
  localparam logic [CW:0]   OCC_MAX  = (CW + 1)'(P);

  // The phase is fully determined by cnt, inflight and the output register,
  // so it is decoded each cycle rather than held in its own register.
  typedef enum logic [1:0] {S_FILL, S_HOLD, S_CLOSE} state_t;

  state_t        state;
  logic [W-1:0]  asm_reg;
  logic [W-1:0]  keep_mask;
  logic [CW-1:0] cnt;
  logic          inflight;
  logic [CW:0]   occupancy;
  logic          close_req;
  logic          out_free;

  // An entry in flight already owns a slot, so it counts against the word.
  always_comb begin
    occupancy = {1'b0, cnt} + {{CW{1'b0}}, inflight};
    fifo_rd   = !rst && !fifo_empty && !flush && (occupancy < OCC_MAX);
  end

  always_comb begin
    close_req = (cnt == CNT_FULL) || (flush && !inflight && (cnt != '0));
    out_free  = !out_valid || out_ready;
    state     = S_FILL;
    if (close_req && out_free) begin
      state = S_CLOSE;
    end else if (cnt == CNT_FULL) begin
      state = S_HOLD;
    end
  end

  // Zero every slot at or above cnt so a flushed word carries no stale data.
  always_comb begin
    keep_mask = '0;
    for (int k = 0; k < P; k++) begin
      if (CW'(k) < cnt) begin
        keep_mask[k*M +: M] = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg   <= '0;
      cnt       <= '0;
      inflight  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else begin
      inflight <= fifo_rd;
      if (state == S_CLOSE) begin
        // A close never coincides with a capture: it needs cnt==P or no read in flight.
        out_data  <= asm_reg & keep_mask;
        out_cnt   <= cnt;
        out_valid <= 1'b1;
        asm_reg   <= '0;
        cnt       <= '0;
      end else begin
        if (out_ready) begin
          out_valid <= 1'b0;
        end
        if (inflight) begin
          for (int k = 0; k < P; k++) begin
            if (cnt == CW'(k)) begin
              asm_reg[k*M +: M] <= fifo_data;
            end
          end
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// tb/tb_fifo_nibble_packer.sv - directed self-checking bench for fifo_nibble_packer
//
// Holds a behavioural one-cycle-latency FIFO model, a monitor that logs accepted
// words and read strobes, and directed tests with hand-computed expected words.
module tb_fifo_nibble_packer;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic [3:0]  fifo_data;
  logic        fifo_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_cnt;

  int checks   = 0;
  int failures = 0;

  fifo_nibble_packer #(.M(4), .P(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cnt    (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: wr_count is stepped only by push(), rd_done only by the model.
  logic [3:0] fifo_q[$];
  int wr_count = 0;
  int rd_done  = 0;

  assign fifo_empty = (wr_count == rd_done);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q.delete();
      rd_done   <= wr_count;
      fifo_data <= 4'h0;
    end else if (fifo_rd) begin
      fifo_data <= fifo_q.pop_front();
      rd_done   <= rd_done + 1;
    end
  end

  // Monitor: inputs change just after posedge, so the negedge view predicts the next edge.
  logic [15:0] got_data[$];
  logic [2:0]  got_cnt[$];
  int          rd_count  = 0;
  int          pace_viol = 0;
  logic [4:0]  rd_hist   = 5'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_cnt.push_back(out_cnt);
      end
      if (fifo_rd) rd_count++;
      if ($countones({rd_hist[3:0], fifo_rd}) > 4) pace_viol++;
      rd_hist <= {rd_hist[3:0], fifo_rd};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    fifo_q.push_back(v);
    wr_count++;
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got_data.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    check(tag, got_data.size(), n);
  endtask

  int gb;
  int rb;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    cyc(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_cnt",   out_cnt,   0);
    check("rst_fifo_rd",   fifo_rd,   0);
    rst = 1'b0;
    cyc(2);

    // 1: single full word
    out_ready = 1'b1;
    gb = got_data.size(); rb = rd_count;
    for (int i = 1; i <= 4; i++) push(4'(i));
    wait_words(gb + 1, 40, "t1_done");
    cyc(3);
    check("t1_data",  got_data[gb], 16'h4321);
    check("t1_cnt",   got_cnt[gb], 4);
    check("t1_reads", rd_count - rb, 4);
    check("t1_empty", fifo_empty, 1);

    // 2: sixteen entries, four words in order, read pacing
    gb = got_data.size(); rb = rd_count;
    for (int i = 0; i < 16; i++) push(4'(i));
    wait_words(gb + 4, 120, "t2_done");
    cyc(3);
    check("t2_w0", got_data[gb],     16'h3210);
    check("t2_w1", got_data[gb + 1], 16'h7654);
    check("t2_w2", got_data[gb + 2], 16'hBA98);
    check("t2_w3", got_data[gb + 3], 16'hFEDC);
    check("t2_c3", got_cnt[gb + 3], 4);
    check("t2_reads", rd_count - rb, 16);
    check("t2_pace", pace_viol, 0);

    // 3: backpressure, first word held, second word stalls
    out_ready = 1'b0;
    gb = got_data.size(); rb = rd_count;
    for (int i = 0; i < 8; i++) push(4'(i));
    cyc(20);
    check("t3_valid",  out_valid, 1);
    check("t3_data",   out_data, 16'h3210);
    check("t3_rd_low", fifo_rd, 0);
    check("t3_reads",  rd_count - rb, 8);
    cyc(5);
    check("t3_stable", out_data, 16'h3210);
    check("t3_none",   got_data.size(), gb);
    out_ready = 1'b1;
    cyc(1);
    check("t3_next_valid", out_valid, 1);
    check("t3_next_data",  out_data, 16'h7654);
    cyc(2);
    check("t3_w0", got_data[gb],     16'h3210);
    check("t3_w1", got_data[gb + 1], 16'h7654);

    // 4: flush of a partial word, then flush with nothing captured
    gb = got_data.size();
    push(4'hA); push(4'hB); push(4'hC);
    cyc(6);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(2);
    check("t4_data", got_data[gb], 16'h0CBA);
    check("t4_cnt",  got_cnt[gb], 3);
    gb = got_data.size();
    flush = 1'b1;
    cyc(3);
    check("t4_empty_flush_valid", out_valid, 0);
    flush = 1'b0;
    cyc(1);
    check("t4_empty_flush_words", got_data.size(), gb);

    // 5: flush raised while a read is in flight
    gb = got_data.size(); rb = rd_count;
    push(4'h5);
    cyc(1);
    flush = 1'b1;
    push(4'h6);
    #1;
    check("t5_no_read", fifo_rd, 0);
    cyc(3);
    check("t5_data",  got_data[gb], 16'h0005);
    check("t5_cnt",   got_cnt[gb], 1);
    check("t5_reads", rd_count - rb, 1);
    flush = 1'b0;
    cyc(2);
    flush = 1'b1;
    cyc(3);
    flush = 1'b0;
    check("t5_resume_data", got_data[gb + 1], 16'h0006);
    check("t5_resume_cnt",  got_cnt[gb + 1], 1);

    // 6: reset mid-word with a pending output word, then clean refill
    out_ready = 1'b0;
    push(4'h8); push(4'h9); push(4'hA); push(4'hB);
    push(4'h1); push(4'h2); push(4'h3);
    cyc(9);
    check("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data",  out_data, 0);
    check("t6_rst_cnt",   out_cnt, 0);
    check("t6_rst_rd",    fifo_rd, 0);
    cyc(2);
    rst = 1'b0;
    out_ready = 1'b1;
    gb = got_data.size();
    for (int i = 1; i <= 4; i++) push(4'(i));
    wait_words(gb + 1, 40, "t6_done");
    cyc(8);
    check("t6_data",  got_data[gb], 16'h4321);
    check("t6_cnt",   got_cnt[gb], 4);
    check("t6_count", got_data.size(), gb + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
